// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the direct-mapped instruction cache.
//   fill_state_t     - refill FSM states (IDLE, FILL)
//   DEFAULT_NOP_INSTR - instruction loaded into the decode register on reset/clear
//   addr_split()     - derives TAG/IDX/OFF field widths from the cache geometry
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    int tag_w;
    int idx_w;
    int off_w;
  } addr_split_t;

  // A 32-bit byte address loses its two byte-select bits; the remaining 30 bits
  // are split into word offset, line index and tag.
  function automatic addr_split_t addr_split(input int num_lines, input int line_words);
    addr_split_t s;
    s.off_w = $clog2(line_words);
    s.idx_w = $clog2(num_lines);
    s.tag_w = 30 - s.off_w - s.idx_w;
    return s;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: refill FSM for the instruction cache.
//   clk, reset         - clock, synchronous active-high reset
//   start              - miss seen in IDLE; latch start_tag/start_idx and begin a refill
//   mem_req/mem_addr   - backing read request, held stable until mem_ack
//   mem_ack            - completes one word transfer (ignored in IDLE)
//   state              - current FSM state
//   wr_en/wr_word      - strobe and word slot for writing mem_rdata into the line
//   line_idx/line_tag  - latched line address being refilled
//   line_done          - pulses with the ack of the last word of the line
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int TAG_W = 24,
  parameter int IDX_W = 4,
  parameter int OFF_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [TAG_W-1:0] start_tag,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             mem_ack,
  output fill_state_t      state,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic             wr_en,
  output logic [OFF_W-1:0] wr_word,
  output logic [IDX_W-1:0] line_idx,
  output logic [TAG_W-1:0] line_tag,
  output logic             line_done
);

  logic [OFF_W-1:0] k;
  logic [OFF_W-1:0] k_next;

  assign k_next    = k + OFF_W'(1);
  assign wr_en     = (state == FILL) && mem_ack;
  assign wr_word   = k;
  // LINE_WORDS is a power of two, so the last word index is all ones.
  assign line_done = wr_en && (k == '1);

  // Refill sequencer: mem_req/mem_addr are registered so they stay stable
  // across a slow memory's wait cycles and only move on an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      line_idx <= '0;
      line_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            k        <= '0;
            line_tag <= start_tag;
            line_idx <= start_idx;
            mem_req  <= 1'b1;
            mem_addr <= {start_tag, start_idx, {OFF_W{1'b0}}, 2'b00};
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (k == '1) begin
              state   <= IDLE;
              k       <= '0;
              mem_req <= 1'b0;
            end else begin
              k        <= k_next;
              mem_addr <= {line_tag, line_idx, k_next, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: direct-mapped instruction cache feeding the decode
// instruction register, refilled word-by-word from a slow backing memory.
//   clk, reset            - clock, synchronous active-high reset
//   if_addr               - next-PC byte address from fetch (bits [1:0] ignored)
//   de_stall / de_clear   - hold / flush (to NOP_INSTR) the decode register
//   de_instr              - registered instruction to decode
//   icache_stall          - to hazard unit, high while a miss is being serviced
//   mem_req/mem_addr/mem_ack/mem_rdata - backing memory read handshake
//   hit_count/miss_count  - perf counters, built only when ICACHE_PERF_CNT_EN
//                           is defined; tied to zero otherwise
module icache_fetch_responder
  import icache_pkg::*;
#(
  parameter int          NUM_LINES  = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_addr,
  input  logic        de_stall,
  input  logic        de_clear,
  output logic [31:0] de_instr,
  output logic        icache_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam addr_split_t SPLIT = addr_split(NUM_LINES, LINE_WORDS);
  localparam int TAG_W = SPLIT.tag_w;
  localparam int IDX_W = SPLIT.idx_w;
  localparam int OFF_W = SPLIT.off_w;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             unused_byte_bits;

  assign offset           = if_addr[2 +: OFF_W];
  assign index            = if_addr[2+OFF_W +: IDX_W];
  assign tag              = if_addr[31 -: TAG_W];
  assign unused_byte_bits = ^if_addr[1:0];

  logic [31:0]          data_ram [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  fill_state_t      state;
  logic             hit;
  logic             start_fill;
  logic             wr_en;
  logic             line_done;
  logic [OFF_W-1:0] wr_word;
  logic [IDX_W-1:0] line_idx;
  logic [TAG_W-1:0] line_tag;

  assign hit          = valid[index] && (tag_ram[index] == tag);
  assign start_fill   = (state == IDLE) && !hit;
  assign icache_stall = (state == FILL) || (state == IDLE && !hit);

  icache_refill_ctrl #(
    .TAG_W (TAG_W),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W)
  ) u_refill (
    .clk       (clk),
    .reset     (reset),
    .start     (start_fill),
    .start_tag (tag),
    .start_idx (index),
    .mem_ack   (mem_ack),
    .state     (state),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .line_idx  (line_idx),
    .line_tag  (line_tag),
    .line_done (line_done)
  );

  // Valid bits: the target line is invalidated as its refill begins, so a
  // partly overwritten line can never be mistaken for its old occupant; it
  // becomes valid only once the last word has landed.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (line_done) begin
      valid[line_idx] <= 1'b1;
    end else if (start_fill) begin
      valid[index] <= 1'b0;
    end
  end

  // Data and tag storage carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_ram[{line_idx, wr_word}] <= mem_rdata;
    end
    if (line_done) begin
      tag_ram[line_idx] <= line_tag;
    end
  end

  // Decode register: clear beats any stall, and a refill in progress holds it
  // just like a decode stall does.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_instr <= NOP_INSTR;
    end else if (de_clear) begin
      de_instr <= NOP_INSTR;
    end else if (!icache_stall && !de_stall) begin
      de_instr <= data_ram[{index, offset}];
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Hits count only lookups that actually load the decode register; misses
  // count refills started.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state == IDLE && hit && !de_stall && !de_clear) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_fill) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb_icache_fetch_responder: self-checking bench for icache_fetch_responder.
// A cache-level reference model (lines keyed by index, words as received)
// predicts every output; a vector table covers the cold miss, hand-written
// sequences cover multi-cycle corner cases, then a randomized phase runs.
module tb_icache_fetch_responder;

  localparam int          NL  = 16;
  localparam int          LW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] if_addr;
  logic        de_stall;
  logic        de_clear;
  logic [31:0] de_instr;
  logic        icache_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_fetch_responder dut (
    .clk          (clk),
    .reset        (reset),
    .if_addr      (if_addr),
    .de_stall     (de_stall),
    .de_clear     (de_clear),
    .de_instr     (de_instr),
    .icache_stall (icache_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;

  // Reference model state
  bit          m_known       = 0;
  bit          m_after_reset = 0;
  bit          m_valid [NL];
  int unsigned m_line  [NL];
  logic [31:0] m_data  [NL*LW];
  bit          m_filling = 0;
  int unsigned m_fill_line = 0;
  int          m_k = 0;
  logic [31:0] m_instr = NOP;
  int unsigned m_hits = 0;
  int unsigned m_misses = 0;

  // Memory responder state
  int ack_wait    = 0;
  bit random_mode = 0;
  bit spurious_en = 0;

  // Combinational outputs captured just after inputs settle
  logic        snap_stall;
  logic        snap_req;
  logic [31:0] snap_addr;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  function automatic int pickDelay();
    if (random_mode) return int'($urandom_range(0, 3));
    return 2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after a negedge, check combinational
  // outputs, advance the model at the posedge, check registered outputs at
  // the following negedge.
  task automatic applyStimulus(input logic [31:0] a, input logic st, input logic cl,
                               input logic rst, input logic ack, input logic [31:0] rd);
    int unsigned ln;
    int          idx;
    int          off;
    bit          hit;
    bit          exp_stall;
    logic [31:0] exp_addr;
    if_addr   = a;
    de_stall  = st;
    de_clear  = cl;
    reset     = rst;
    mem_ack   = ack;
    mem_rdata = rd;
    ln  = a >> 4;
    idx = int'(ln % NL);
    off = int'((a >> 2) % LW);
    hit = m_valid[idx] && (m_line[idx] == ln);
    exp_stall = m_filling || !hit;
    exp_addr  = (m_fill_line << 4) + (m_k << 2);
    #1;
    snap_stall = icache_stall;
    snap_req   = mem_req;
    snap_addr  = mem_addr;
    if (m_known) begin
      checkOutput("icache_stall", icache_stall, exp_stall);
      checkOutput("mem_req", mem_req, m_filling);
      if (m_filling) checkOutput("mem_addr", mem_addr, exp_addr);
      else if (m_after_reset) checkOutput("mem_addr_reset", mem_addr, 32'h0);
    end
    @(posedge clk);
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_filling = 0;
      m_k = 0;
      m_instr = NOP;
      m_hits = 0;
      m_misses = 0;
      m_known = 1;
      m_after_reset = 1;
    end else if (m_known) begin
      if (cl) m_instr = NOP;
      else if (!exp_stall && !st) m_instr = m_data[idx*LW + off];
      if (!m_filling) begin
        if (!hit) begin
          m_filling = 1;
          m_fill_line = ln;
          m_k = 0;
          m_misses++;
          m_after_reset = 0;
          ack_wait = pickDelay();
        end else if (!st && !cl) begin
          m_hits++;
        end
      end else if (ack) begin
        m_data[int'(m_fill_line % NL)*LW + m_k] = rd;
        m_k++;
        if (m_k == LW) begin
          m_valid[int'(m_fill_line % NL)] = 1;
          m_line[int'(m_fill_line % NL)]  = m_fill_line;
          m_filling = 0;
          m_k = 0;
        end
      end
    end
    @(negedge clk);
    if (m_known) begin
      checkOutput("de_instr", de_instr, m_instr);
`ifdef ICACHE_PERF_CNT_EN
      checkOutput("hit_count", hit_count, m_hits);
      checkOutput("miss_count", miss_count, m_misses);
`else
      checkOutput("hit_count_tied", hit_count, 32'h0);
      checkOutput("miss_count_tied", miss_count, 32'h0);
`endif
    end
  endtask

  // Cycle with the bench's backing memory answering requests.
  task automatic applyCycle(input logic [31:0] a, input logic st, input logic cl,
                            input logic rst, output logic acked);
    logic        ack;
    logic [31:0] rd;
    ack = 1'b0;
    rd  = 32'h0;
    if (m_filling) begin
      if (ack_wait == 0) begin
        ack = 1'b1;
        rd  = memval((m_fill_line << 4) + (m_k << 2));
        ack_wait = pickDelay();
      end else begin
        ack_wait--;
      end
    end else if (spurious_en && $urandom_range(0, 3) == 0) begin
      ack = 1'b1;
      rd  = $urandom;
    end
    acked = ack && m_filling && !rst;
    applyStimulus(a, st, cl, rst, ack, rd);
  endtask

  // Present an address until a refill it triggers has completed.
  task automatic runFill(input logic [31:0] a, input int clear_at, input int redirect_after,
                         input logic [31:0] redirect_addr, output int acks,
                         output logic [31:0] first_addr);
    logic [31:0] cur;
    logic        ackd;
    bit          started;
    bit          have_first;
    cur = a;
    acks = 0;
    first_addr = 32'hFFFF_FFFF;
    started = 0;
    have_first = 0;
    for (int c = 0; c < 200; c++) begin
      if (m_filling && !have_first) begin
        first_addr = mem_addr;
        have_first = 1;
      end
      applyCycle(cur, 1'b0, (c == clear_at), 1'b0, ackd);
      if (ackd) acks++;
      if (redirect_after >= 0 && acks >= redirect_after) cur = redirect_addr;
      if (m_filling) started = 1;
      else if (started) break;
    end
    if (m_filling || !started) begin
      tests++;
      failures++;
      $display("[TB] FAIL fill_bound: refill of %h did not complete (started=%0d)", a, started);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic        st;
    logic        cl;
    logic        ack;
    logic [31:0] rd;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          acks;
    logic [31:0] fa;
    logic        ackd;
    logic [31:0] ra;

    // Cold miss of address 0: ack two cycles after each request word.
    vecs[0]  = '{32'h0, 0, 0, 0, 32'h0,  1, 0, 32'h0, NOP};
    vecs[1]  = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'h0, NOP};
    vecs[2]  = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'h0, NOP};
    vecs[3]  = '{32'h0, 0, 0, 1, 32'hA0, 1, 1, 32'h0, NOP};
    vecs[4]  = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'h4, NOP};
    vecs[5]  = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'h4, NOP};
    vecs[6]  = '{32'h0, 0, 0, 1, 32'hA1, 1, 1, 32'h4, NOP};
    vecs[7]  = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'h8, NOP};
    vecs[8]  = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'h8, NOP};
    vecs[9]  = '{32'h0, 0, 0, 1, 32'hA2, 1, 1, 32'h8, NOP};
    vecs[10] = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'hC, NOP};
    vecs[11] = '{32'h0, 0, 0, 0, 32'h0,  1, 1, 32'hC, NOP};
    vecs[12] = '{32'h0, 0, 0, 1, 32'hA3, 1, 1, 32'hC, NOP};
    vecs[13] = '{32'h0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 32'hA0};
    vecs[14] = '{32'h4, 0, 0, 0, 32'h0,  0, 0, 32'h0, 32'hA1};
    vecs[15] = '{32'h8, 0, 0, 0, 32'h0,  0, 0, 32'h0, 32'hA2};
    vecs[16] = '{32'hC, 0, 0, 0, 32'h0,  0, 0, 32'h0, 32'hA3};

    if_addr = 32'h0; de_stall = 0; de_clear = 0; reset = 1; mem_ack = 0; mem_rdata = 0;
    @(negedge clk);
    applyStimulus(32'h0, 0, 0, 1, 0, 32'h0);
    applyStimulus(32'h0, 0, 0, 1, 0, 32'h0);
    checkOutput("reset de_instr", de_instr, NOP);
    checkOutput("reset mem_req", mem_req, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].a, vecs[i].st, vecs[i].cl, 1'b0, vecs[i].ack, vecs[i].rd);
      checkOutput($sformatf("vec%0d stall", i), snap_stall, vecs[i].e_stall);
      checkOutput($sformatf("vec%0d req", i), snap_req, vecs[i].e_req);
      if (vecs[i].e_req) checkOutput($sformatf("vec%0d addr", i), snap_addr, vecs[i].e_addr);
      checkOutput($sformatf("vec%0d instr", i), de_instr, vecs[i].e_instr);
    end

    // Conflict eviction: 0x100 shares index 0 with 0x000.
    runFill(32'h100, -1, -1, 32'h0, acks, fa);
    checkOutput("conflict acks", acks, 4);
    checkOutput("conflict first addr", fa, 32'h100);
    applyCycle(32'h100, 0, 0, 0, ackd);
    checkOutput("conflict hit data", de_instr, 32'hE0);
    runFill(32'h0, -1, -1, 32'h0, acks, fa);
    checkOutput("evicted remiss acks", acks, 4);
    checkOutput("evicted remiss addr", fa, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
    checkOutput("miss_count after conflict", miss_count, 32'd3);
`else
    checkOutput("miss_count tied off", miss_count, 32'd0);
`endif

    // de_stall on a hit holds the register while the address moves.
    applyCycle(32'h0, 0, 0, 0, ackd);
    checkOutput("stall pre", de_instr, 32'hA0);
    for (int i = 0; i < 3; i++) begin
      applyCycle(32'h4, 1, 0, 0, ackd);
      checkOutput("stall hold", de_instr, 32'hA0);
    end
    applyCycle(32'h4, 0, 0, 0, ackd);
    checkOutput("stall release", de_instr, 32'hA1);

    // de_clear beats de_stall; de_clear during a refill does not abort it.
    applyCycle(32'h8, 1, 1, 0, ackd);
    checkOutput("clear over stall", de_instr, NOP);
    applyCycle(32'h8, 0, 0, 0, ackd);
    checkOutput("reload after clear", de_instr, 32'hA2);
    runFill(32'h300, 3, -1, 32'h0, acks, fa);
    checkOutput("clear in fill acks", acks, 4);
    checkOutput("clear in fill addr", fa, 32'h300);
    checkOutput("clear in fill instr", de_instr, NOP);
    applyCycle(32'h300, 0, 0, 0, ackd);
    checkOutput("after cleared fill", de_instr, 32'h160);

    // Reset after the second ack of a refill aborts it.
    acks = 0;
    for (int c = 0; c < 50 && acks < 2; c++) begin
      applyCycle(32'h40, 0, 0, 0, ackd);
      if (ackd) acks++;
    end
    checkOutput("pre reset acks", acks, 2);
    applyCycle(32'h40, 0, 0, 1, ackd);
    checkOutput("mid fill reset instr", de_instr, NOP);
    checkOutput("mid fill reset req", mem_req, 32'h0);
    runFill(32'h40, -1, -1, 32'h0, acks, fa);
    checkOutput("refill after reset acks", acks, 4);
    checkOutput("refill after reset addr", fa, 32'h40);
    applyCycle(32'h40, 0, 0, 0, ackd);
    checkOutput("refill after reset data", de_instr, 32'hB0);

    // Redirect mid-refill: the latched line finishes, then 0x200 is fetched.
    runFill(32'h0, -1, 1, 32'h200, acks, fa);
    checkOutput("redirect acks", acks, 4);
    checkOutput("redirect first addr", fa, 32'h0);
    runFill(32'h200, -1, -1, 32'h0, acks, fa);
    checkOutput("redirect new fill acks", acks, 4);
    checkOutput("redirect new fill addr", fa, 32'h200);
    applyCycle(32'h200, 0, 0, 0, ackd);
    checkOutput("redirect new data", de_instr, 32'h120);

    // Randomized traffic over a small address pool to mix hits and conflicts,
    // with variable ack latency, stray acks while idle and occasional resets.
    random_mode = 1;
    spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 4) |
           ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      applyCycle(ra, ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 299) == 0), ackd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
